// File: rtl/deserializer_nlane_if.sv
// Stream handshake bundle: a WIDTH-bit payload with valid/ready.
//   master: drives data and valid, observes ready
//   slave : observes data and valid, drives ready
interface deserializer_nlane_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/deserializer_nlane.sv
// Multi-lane deserializer: assembles LANES-bit beats into WORD_WIDTH-bit words.
// A one-word output register plus a one-word assembly buffer allow
// back-to-back words with no bubble cycles.
//   i_clk     : clock, all state on rising edge
//   i_rst     : asynchronous active-high reset
//   i_en      : clock enable, freezes all state when low
//   i_flush   : synchronous discard of the partial/pending word
//   s_beat    : input beats (data = beat, valid = beat valid, ready = o_ready)
//   m_word    : output words (data = ov_dout, valid = o_dout_valid, ready = i_ready)
//   o_partial : word in progress (beat counter nonzero)
module deserializer_nlane #(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned LANES      = 1,
  parameter bit          MSB_FIRST  = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_flush,
  deserializer_nlane_if.slave   s_beat,
  deserializer_nlane_if.master  m_word,
  output logic                  o_partial
);

  localparam int unsigned BEATS = WORD_WIDTH / LANES;
  localparam int unsigned CNT_W = $clog2(BEATS) + 1;

  typedef enum logic {ST_COLLECT, ST_FULL} state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [WORD_WIDTH-1:0]   asm_q;
  logic [WORD_WIDTH-1:0]   dout_q;
  logic                    dout_valid_q;
  logic [WORD_WIDTH-1:0]   shifted_c;
  logic                    ready_c;
  logic                    beat_xfer_c;
  logic                    out_xfer_c;
  logic                    last_beat_c;

  // Ready is held low while reset is asserted so nothing is offered upstream.
  assign ready_c     = ~i_rst & i_en & ~i_flush & (state_q == ST_COLLECT);
  assign beat_xfer_c = s_beat.valid & ready_c;
  assign out_xfer_c  = i_en & dout_valid_q & m_word.ready;
  assign last_beat_c = (cnt_q == CNT_W'(BEATS - 1));

  // Assembly register with the incoming beat shifted in.
  generate
    if (BEATS == 1) begin : g_single
      assign shifted_c = s_beat.data;
    end else if (MSB_FIRST) begin : g_msb
      assign shifted_c = {asm_q[WORD_WIDTH-LANES-1:0], s_beat.data};
    end else begin : g_lsb
      assign shifted_c = {s_beat.data, asm_q[WORD_WIDTH-1:LANES]};
    end
  endgenerate

  // Collect/full state machine with the output register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_COLLECT;
      cnt_q        <= '0;
      asm_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      o_partial    <= 1'b0;
    end else if (i_en) begin
      // A drained word clears valid unless a new word is loaded below.
      if (out_xfer_c) begin
        dout_valid_q <= 1'b0;
      end
      if (i_flush) begin
        state_q   <= ST_COLLECT;
        cnt_q     <= '0;
        asm_q     <= '0;
        o_partial <= 1'b0;
      end else if (state_q == ST_COLLECT) begin
        if (beat_xfer_c) begin
          if (last_beat_c) begin
            cnt_q     <= '0;
            o_partial <= 1'b0;
            if (!dout_valid_q || out_xfer_c) begin
              dout_q       <= shifted_c;
              dout_valid_q <= 1'b1;
              asm_q        <= '0;
            end else begin
              // Output still occupied: park the word and stall upstream.
              asm_q   <= shifted_c;
              state_q <= ST_FULL;
            end
          end else begin
            asm_q     <= shifted_c;
            cnt_q     <= cnt_q + CNT_W'(1);
            o_partial <= 1'b1;
          end
        end
      end else begin
        if (out_xfer_c) begin
          dout_q       <= asm_q;
          dout_valid_q <= 1'b1;
          asm_q        <= '0;
          state_q      <= ST_COLLECT;
        end
      end
    end
  end

  assign s_beat.ready = ready_c;
  assign m_word.data  = dout_q;
  assign m_word.valid = dout_valid_q;

endmodule

// File: doc/deserializer_nlane.md
Name: deserializer_nlane

Overview:
Parametrised serial-to-parallel converter that assembles LANES-bit beats into WORD_WIDTH-bit words. It has valid/ready handshakes on both sides and a selectable bit order. A one-word output register plus a one-word assembly buffer allow back-to-back words with no bubble cycles. It sits between the serial stimulus/link interface and the FIR datapath, and is the multi-lane, back-pressure-aware replacement for the single-bit deserializer.

Parameters:
WORD_WIDTH, 32, width of the assembled output word; must be a multiple of LANES.
LANES, 1, bits accepted per input beat (1, 2, 4, 8...).
MSB_FIRST, 0, 0: the first beat lands in bits [LANES-1:0]; 1: the first beat lands in bits [WORD_WIDTH-1:WORD_WIDTH-LANES].

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst  in  1  asynchronous, active-high reset
i_en  in  1  clock enable; when low, all state is frozen
i_flush  in  1  synchronous; discards any partial or pending word
iv_din  in  LANES  input beat
i_din_valid  in  1  upstream beat valid
o_ready  out  1  deserializer can accept a beat (combinational)
ov_dout  out  WORD_WIDTH  assembled word
o_dout_valid  out  1  ov_dout holds an untransferred word
i_ready  in  1  downstream (FIR) ready
o_partial  out  1  beat counter nonzero (word in progress)

Behaviour:
- BEATS = WORD_WIDTH/LANES. Beat counter is clog2(BEATS)+1 bits wide and counts 0..BEATS-1. Assembly register is WORD_WIDTH bits.
- Reset (async, i_rst=1): state=COLLECT, counter=0, assembly=0, ov_dout=0, o_dout_valid=0, o_partial=0, o_ready=0.
- o_ready = i_en & ~i_flush & (state==COLLECT). It is combinational and has no dependence on i_din_valid.
- Input beat transfer = i_din_valid & o_ready.
- Output transfer = i_en & o_dout_valid & i_ready. i_ready is ignored while i_en=0.
- Bit order, LSB-first: each beat shifts right, new beat enters the top LANES bits; after BEATS beats the first beat sits at [LANES-1:0]. MSB-first: each beat shifts left, new beat enters the bottom LANES bits.
- State machine, states COLLECT and FULL:
  - COLLECT, beat accepted, counter<BEATS-1: shift the beat in, counter+1.
  - COLLECT, beat accepted, counter==BEATS-1, and (o_dout_valid=0 or output transfer this cycle): load ov_dout with the shifted value, o_dout_valid=1, counter=0, stay in COLLECT. This gives zero bubble.
  - COLLECT, beat accepted, counter==BEATS-1, output register occupied and not draining: store the shifted word in assembly, counter=0, go to FULL.
  - FULL: o_ready=0. On output transfer: ov_dout <= assembly, o_dout_valid stays 1, assembly=0, go to COLLECT.
- o_dout_valid clears on an output transfer with no new load in the same cycle.
- Latency: a word is valid on ov_dout the cycle after its last beat is accepted. Throughput is one word per BEATS cycles at full rate.
- i_flush=1 (with i_en=1): counter=0, assembly=0, state=COLLECT. A beat presented that cycle is not accepted. ov_dout and o_dout_valid are untouched, and an output transfer in the same cycle still completes.
- i_en=0: no register changes, o_ready=0, ov_dout and o_dout_valid hold.
- Reset asserted mid-word or in FULL: everything is cleared immediately. The partial and pending words are lost and no word is emitted.
- o_partial = (counter != 0), registered with the counter.

Test Plan:
- WORD_WIDTH=8, LANES=1, MSB_FIRST=0, bits 1,0,1,1,0,0,1,0 with i_ready=1 -> ov_dout=0x4D, o_dout_valid high one cycle after the 8th beat. With MSB_FIRST=1, the same bits -> 0xB2.
- WORD_WIDTH=16, LANES=4, beats 0xA,0xB,0xC,0xD -> 0xDCBA (LSB-first) and 0xABCD (MSB-first).
- Continuous valid, i_ready=1, 3 words at LANES=4/WORD_WIDTH=16 -> o_dout_valid asserted for 3 transfers spaced exactly 4 cycles apart, o_ready never low.
- i_ready=0, stream two words 0x1234, 0x5678 -> after the 2nd word o_ready=0 (FULL) and further beats are stalled. Pulse i_ready -> 0x1234 transfers, 0x5678 appears the next cycle, o_ready returns to 1.
- Two beats into a word, assert i_flush one cycle, then send a full word 0xBEEF -> output 0xBEEF, with no residue from the flushed beats. Repeat with async i_rst mid-word -> outputs 0 and o_dout_valid=0 immediately.
- i_en=0 for 5 cycles mid-word with din toggling -> counter, assembly and ov_dout unchanged, and the word completes correctly after i_en returns high.
